// File: rtl/cmp_sched_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the round-robin compare scheduler.
package cmp_sched_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Upper bound on requesters the round-robin search can handle.
    localparam int unsigned MAX_REQ = 32;

    // First set request searching upward from ptr+1, wrapping modulo nreq.
    // Returns 0 when no request is set; callers only use it with req != 0.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        ptr,
                                            input int unsigned        nreq);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= nreq) begin
                idx = ptr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (!found && req[idx]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/twobit_greater_than.sv
`timescale 1ns/1ps
// Gate-level 2-bit unsigned greater-than: gt = (a > b).
module twobit_greater_than (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);

    // MSB wins outright; on equal MSBs the LSB decides.
    assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);

endmodule

// File: rtl/cmp_rr_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one serial 2-bit-slice comparator among
// NREQ requesters; reports agtb = (a > b) tagged with the requester id.
module cmp_rr_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       a_flat,
    input  logic [NREQ*W-1:0]       b_flat,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic                    agtb,
    output logic [$clog2(NREQ)-1:0] done_id
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned SL  = W / 2;
    localparam int unsigned IW  = (SL > 1) ? $clog2(SL) : 1;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               decided_q, decided_d;
    logic               res_q, res_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               done_q, done_d;
    logic               agtb_q, agtb_d;
    logic [IDW-1:0]     done_id_q, done_id_d;

    logic [MAX_REQ-1:0] req_ext;
    int unsigned        pick;
    logic [1:0]         a_s, b_s;
    logic               ab_gt, ba_gt;

    // Current slice of each captured operand, selected by the slice index.
    assign a_s = 2'(a_q >> {idx_q, 1'b0});
    assign b_s = 2'(b_q >> {idx_q, 1'b0});

    twobit_greater_than gt_ab (.a(a_s), .b(b_s), .gt(ab_gt));
    twobit_greater_than gt_ba (.a(b_s), .b(a_s), .gt(ba_gt));

    // State, operand capture, slice counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NREQ - 1);
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            res_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            agtb_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            res_q     <= res_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            agtb_q    <= agtb_d;
            done_id_q <= done_id_d;
        end
    end

    // Arbitration in IDLE, one MSB-first slice per cycle in RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        res_d     = res_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        agtb_d    = agtb_q;
        done_id_d = done_id_q;
        req_ext   = '0;
        req_ext[NREQ-1:0] = req;
        pick      = rr_pick(req_ext, 32'(ptr_q), NREQ);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (i == pick) begin
                            gnt_d[i] = 1'b1;
                            a_d      = a_flat[i*W +: W];
                            b_d      = b_flat[i*W +: W];
                        end
                    end
                    id_d      = IDW'(pick);
                    ptr_d     = IDW'(pick);
                    idx_d     = IW'(SL - 1);
                    decided_d = 1'b0;
                    res_d     = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // The first unequal slice fixes the result; later slices are ignored.
                if (!decided_q && ab_gt) begin
                    decided_d = 1'b1;
                    res_d     = 1'b1;
                end else if (!decided_q && ba_gt) begin
                    decided_d = 1'b1;
                    res_d     = 1'b0;
                end
                if (idx_q == '0) begin
                    agtb_d    = res_d;
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign agtb    = agtb_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
`timescale 1ns/1ps
// Randomized and directed bench for cmp_rr_scheduler against a behavioural model.
module tb_cmp_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_flat, b_flat;
    logic [NREQ-1:0]   gnt;
    logic              busy, done, agtb;
    logic [1:0]        done_id;

    logic [1:0]        req2;
    logic [3:0]        a2_flat, b2_flat;
    logic [1:0]        gnt2;
    logic              busy2, done2, agtb2;
    logic [0:0]        done_id2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pointer, running job and expected outputs.
    int           m_ptr, m_rem, m_id, m_a, m_b;
    bit           m_run;
    logic [3:0]   e_gnt;
    bit           e_busy, e_done, e_agtb;
    int           e_id;
    int           cyc = 0;
    bit           reraise = 0;
    int           g_log[$];
    int           g_cyc[$];

    always #5 clk = ~clk;

    cmp_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt), .busy(busy), .done(done), .agtb(agtb), .done_id(done_id)
    );

    cmp_rr_scheduler #(.NREQ(2), .W(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .a_flat(a2_flat), .b_flat(b2_flat),
        .gnt(gnt2), .busy(busy2), .done(done2), .agtb(agtb2), .done_id(done_id2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_run  = 0;
        m_rem  = 0;
        e_gnt  = '0;
        e_busy = 0;
        e_done = 0;
        e_agtb = 0;
        e_id   = 0;
    endtask

    // One clock: predict from pre-edge inputs, advance, compare, apply requester rule.
    task automatic cycle();
        int pick;
        e_gnt  = '0;
        e_done = 0;
        if (reset) begin
            model_reset();
        end else if (m_run) begin
            m_rem--;
            if (m_rem == 0) begin
                m_run  = 0;
                e_done = 1;
                e_agtb = (m_a > m_b);
                e_id   = m_id;
            end
        end else if (req != 0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (pick < 0 && req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
            end
            e_gnt[pick] = 1'b1;
            m_ptr = pick;
            m_id  = pick;
            m_a   = int'(a_flat[pick*W +: W]);
            m_b   = int'(b_flat[pick*W +: W]);
            m_rem = W / 2;
            m_run = 1;
        end
        e_busy = m_run;
        @(posedge clk);
        #1;
        cyc++;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("agtb", 32'(agtb), 32'(e_agtb));
        check("done_id", 32'(done_id), 32'(e_id));
        for (int i = 0; i < NREQ; i++) begin
            if (e_gnt[i]) begin
                g_log.push_back(i);
                g_cyc.push_back(cyc);
                req[i] = 1'b0;
                a_flat[i*W +: W] = 4'($urandom);
                b_flat[i*W +: W] = 4'($urandom);
            end
        end
        if (reraise && e_done) req[e_id] = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
    endtask

    initial begin
        logic [3:0] ra;
        reset   = 1'b1;
        req     = '0;
        a_flat  = '0;
        b_flat  = '0;
        req2    = '0;
        a2_flat = '0;
        b2_flat = '0;
        model_reset();
        cycle();
        cycle();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);
        reset = 1'b0;
        cycle();

        // Directed: a > b decided in the low slice
        set_op(0, 4'b1011, 4'b1001);
        req = 4'b0001;
        cycle();
        check("t1_gnt", 32'(gnt), 32'h1);
        cycle();
        cycle();
        check("t1_done", 32'(done), 32'h1);
        check("t1_agtb", 32'(agtb), 32'h1);
        check("t1_id", 32'(done_id), 32'h0);

        // Directed: equal operands
        set_op(2, 4'b0110, 4'b0110);
        req = 4'b0100;
        cycle();
        check("t2_gnt", 32'(gnt), 32'h4);
        cycle();
        cycle();
        check("t2_agtb", 32'(agtb), 32'h0);
        check("t2_id", 32'(done_id), 32'h2);

        // Directed: MSB slice decides, low slice ignored
        set_op(1, 4'b0111, 4'b1000);
        req = 4'b0010;
        cycle();
        cycle();
        cycle();
        check("t3_done", 32'(done), 32'h1);
        check("t3_agtb", 32'(agtb), 32'h0);
        check("t3_id", 32'(done_id), 32'h1);
        cycle();

        // Full contention with re-raise in each done cycle; ptr currently 1
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        g_log.delete();
        g_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_op(i, 4'($urandom), 4'($urandom));
        req = 4'b1111;
        reraise = 1;
        for (int n = 0; n < 14; n++) cycle();
        reraise = 0;
        req = '0;
        for (int n = 0; n < 4; n++) cycle();
        check("t4_ngrants", 32'(g_log.size() >= 5), 32'd1);
        if (g_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("t4_order", 32'(g_log[k]), 32'(k % NREQ));
            for (int k = 1; k < 5; k++) check("t4_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
        end

        // Reset while id 3 is running: no done afterwards
        set_op(3, 4'b1111, 4'b0000);
        req = 4'b1000;
        cycle();
        check("t5_gnt", 32'(gnt), 32'h8);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_agtb", 32'(agtb), 32'd0);
        check("t5_rst_id", 32'(done_id), 32'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        g_log.delete();
        g_cyc.delete();
        set_op(0, 4'b0101, 4'b0011);
        set_op(2, 4'b0001, 4'b1001);
        req = 4'b0101;
        for (int n = 0; n < 8; n++) cycle();
        check("t5_ngrants", 32'(g_log.size()), 32'd2);
        if (g_log.size() >= 2) begin
            check("t5_first", 32'(g_log[0]), 32'd0);
            check("t5_second", 32'(g_log[1]), 32'd2);
        end

        // Randomized traffic following the requester rule
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    ra = 4'($urandom);
                    set_op(i, ra, ($urandom_range(0, 3) == 0) ? ra : 4'($urandom));
                    req[i] = 1'b1;
                end
            end
            cycle();
        end
        req = '0;
        for (int n = 0; n < 4; n++) cycle();

        // W=2, NREQ=2: exhaustive sweep on requester 0
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                req2    = 2'b01;
                a2_flat = 4'(a);
                b2_flat = 4'(b);
                @(posedge clk);
                #1;
                check("t6_gnt", 32'(gnt2), 32'h1);
                check("t6_busy", 32'(busy2), 32'h1);
                check("t6_nodone", 32'(done2), 32'h0);
                req2    = 2'b00;
                a2_flat = 4'($urandom);
                b2_flat = 4'($urandom);
                @(posedge clk);
                #1;
                check("t6_done", 32'(done2), 32'h1);
                check("t6_agtb", 32'(agtb2), 32'(a > b));
                check("t6_id", 32'(done_id2), 32'h0);
                check("t6_idle", 32'(busy2), 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
